// File: rtl/led_channel_blinker_if.sv
// Configuration write bus for led_channel_blinker: valid/ready write handshake
// plus a one-cycle error pulse for writes addressed to a missing channel.
interface led_channel_blinker_if #(
  parameter int PERIOD_W = 16,
  parameter int PWM_BITS = 8
);
  logic                cfg_valid;
  logic                cfg_ready;
  logic [3:0]          cfg_chan;
  logic [1:0]          cfg_mode;
  logic [PERIOD_W-1:0] cfg_period;
  logic [PWM_BITS-1:0] cfg_duty;
  logic                cfg_err;

  modport master (
    output cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_duty,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_chan, cfg_mode, cfg_period, cfg_duty,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/led_channel_blinker.sv
// Multi-channel LED driver: per-channel OFF / ON / BLINK / PWM with a shared
// tick prescaler and a shared free-running PWM counter.
module led_channel_blinker #(
  parameter int CHANNELS       = 4,
  parameter int TICK_DIV       = 100_000,
  parameter int PERIOD_W       = 16,
  parameter int PWM_BITS       = 8,
  parameter int DEFAULT_PERIOD = 500
) (
  input  logic                clk,
  input  logic                reset,
  led_channel_blinker_if.slave cfg,
  output logic                tick,
  output logic [CHANNELS-1:0] led
);

  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e               mode;
    logic [PERIOD_W-1:0] period;
    logic [PWM_BITS-1:0] duty;
    logic [PERIOD_W-1:0] cnt;
    logic                phase;
  } chan_t;

  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic                rdy_q;
  logic                err_q, err_d;
  logic [CHANNELS-1:0] led_q, led_d;
  chan_t               ch_q [CHANNELS];
  chan_t               ch_d [CHANNELS];

  logic accept;
  logic chan_ok;

  // A period of 0 behaves as 1: the counter wraps on every tick.
  function automatic logic [PERIOD_W-1:0] last_count(input logic [PERIOD_W-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  assign tick          = (presc_q == PRESC_W'(TICK_DIV - 1));
  assign cfg.cfg_ready = rdy_q & ~reset;
  assign cfg.cfg_err   = err_q;
  assign led           = led_q;
  assign accept        = cfg.cfg_valid & cfg.cfg_ready;
  assign chan_ok       = int'(cfg.cfg_chan) < CHANNELS;

  always_comb begin
    presc_d   = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d = pwm_cnt_q + 1'b1;
    err_d     = accept & ~chan_ok;
    led_d     = '0;

    for (int unsigned i = 0; i < CHANNELS; i++) begin
      ch_d[i] = ch_q[i];

      unique case (ch_q[i].mode)
        MODE_OFF:   led_d[i] = 1'b0;
        MODE_ON:    led_d[i] = 1'b1;
        MODE_BLINK: led_d[i] = ch_q[i].phase;
        MODE_PWM:   led_d[i] = (pwm_cnt_q < ch_q[i].duty);
        default:    led_d[i] = 1'b0;
      endcase

      if (ch_q[i].mode != MODE_BLINK) begin
        ch_d[i].cnt = '0;
      end else if (tick) begin
        if (ch_q[i].cnt == last_count(ch_q[i].period)) begin
          ch_d[i].cnt   = '0;
          ch_d[i].phase = ~ch_q[i].phase;
        end else begin
          ch_d[i].cnt = ch_q[i].cnt + 1'b1;
        end
      end

      // A write overrides any tick-driven update on the same edge.
      if (accept && chan_ok && (cfg.cfg_chan == 4'(i))) begin
        ch_d[i].mode   = mode_e'(cfg.cfg_mode);
        ch_d[i].period = cfg.cfg_period;
        ch_d[i].duty   = cfg.cfg_duty;
        ch_d[i].cnt    = '0;
        ch_d[i].phase  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      led_q     <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        ch_q[i].mode   <= MODE_OFF;
        ch_q[i].period <= PERIOD_W'(DEFAULT_PERIOD);
        ch_q[i].duty   <= '0;
        ch_q[i].cnt    <= '0;
        ch_q[i].phase  <= 1'b0;
      end
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      rdy_q     <= 1'b1;
      err_q     <= err_d;
      led_q     <= led_d;
      ch_q      <= ch_d;
    end
  end

endmodule

// File: tb/tb_led_channel_blinker.sv
// Bench for led_channel_blinker: directed vector table, timing sequences for
// blink/PWM/collision, and randomized traffic against an arithmetic model.
module tb_led_channel_blinker;

  localparam int CH = 4;
  localparam int TD = 4;
  localparam int PW = 16;
  localparam int PB = 8;
  localparam int DP = 500;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [CH-1:0] led;

  led_channel_blinker_if #(.PERIOD_W(PW), .PWM_BITS(PB)) cfg_if ();

  led_channel_blinker #(
    .CHANNELS(CH), .TICK_DIV(TD), .PERIOD_W(PW), .PWM_BITS(PB), .DEFAULT_PERIOD(DP)
  ) dut (
    .clk(clk), .reset(reset), .cfg(cfg_if), .tick(tick), .led(led)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: edges since reset release, plus each channel's last accepted write.
  int t_now = 0;
  int m_mode [CH];
  int m_per  [CH];
  int m_duty [CH];
  int m_wr   [CH];

  logic [CH-1:0] last_led = '0;
  logic [CH-1:0] prev_led = '0;

  typedef struct {
    bit      rst;
    bit      vld;
    int      ch;
    int      md;
    int      per;
    int      dty;
    bit      x_ready;
    logic [3:0] x_led;
    bit      x_err;
    bit      x_tick;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @t=%0d: got %0h, expected %0h", name, t_now, act, exp);
    end
  endtask

  // LED of channel c after edge t, from configuration as it stood after edge t-1.
  function automatic bit model_led(input int c, input int t);
    int p;
    int nt;
    case (m_mode[c])
      1: return 1'b1;
      2: begin
        p  = (m_per[c] == 0) ? 1 : m_per[c];
        nt = (t - 1) / TD - m_wr[c] / TD;
        return ((nt / p) % 2) == 1;
      end
      3: return ((t - 1) % 256) < m_duty[c];
      default: return 1'b0;
    endcase
  endfunction

  task automatic step(input bit rst, input bit vld, input int ch, input int md,
                      input int per, input int dty,
                      output bit o_ready, output bit o_err, output bit o_tick,
                      output logic [CH-1:0] o_led,
                      output bit e_ready, output bit e_err, output bit e_tick,
                      output logic [CH-1:0] e_led);
    int t;
    reset             = rst;
    cfg_if.cfg_valid  = vld;
    cfg_if.cfg_chan   = 4'(ch);
    cfg_if.cfg_mode   = 2'(md);
    cfg_if.cfg_period = PW'(per);
    cfg_if.cfg_duty   = PB'(dty);
    #1;
    o_ready = cfg_if.cfg_ready;
    e_ready = !rst && (t_now >= 1);
    if (rst) begin
      e_led  = '0;
      e_err  = 1'b0;
      e_tick = 1'b0;
    end else begin
      t = t_now + 1;
      for (int c = 0; c < CH; c++) e_led[c] = model_led(c, t);
      e_err  = vld && e_ready && (ch >= CH);
      e_tick = (t % TD) == TD - 1;
    end
    @(posedge clk);
    if (rst) begin
      t_now = 0;
      for (int c = 0; c < CH; c++) begin
        m_mode[c] = 0; m_per[c] = DP; m_duty[c] = 0; m_wr[c] = 0;
      end
    end else begin
      t_now++;
      if (vld && e_ready && ch < CH) begin
        m_mode[ch] = md; m_per[ch] = per; m_duty[ch] = dty; m_wr[ch] = t_now;
      end
    end
    @(negedge clk);
    o_led  = led;
    o_err  = cfg_if.cfg_err;
    o_tick = tick;
  endtask

  task automatic run_chk(input bit rst, input bit vld, input int ch, input int md,
                         input int per, input int dty);
    bit or_, oe, ot, er, ee, et;
    logic [CH-1:0] ol, el;
    prev_led = last_led;
    step(rst, vld, ch, md, per, dty, or_, oe, ot, ol, er, ee, et, el);
    chk("ready", 32'(or_), 32'(er));
    chk("led",   32'(ol),  32'(el));
    chk("err",   32'(oe),  32'(ee));
    chk("tick",  32'(ot),  32'(et));
    last_led = ol;
  endtask

  initial begin
    int w;
    int chg[$];
    int hi;
    int duties[3];
    bit or_, oe, ot, er, ee, et;
    logic [CH-1:0] ol, el;

    reset = 1'b1;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_chan = '0; cfg_if.cfg_mode = '0;
    cfg_if.cfg_period = '0; cfg_if.cfg_duty = '0;

    //            rst vld ch md per dty  rdy led      err tick
    tbl[0]  = '{1, 1, 1, 1, 0, 0,   0, 4'b0000, 0, 0};
    tbl[1]  = '{1, 1, 1, 1, 0, 0,   0, 4'b0000, 0, 0};
    tbl[2]  = '{1, 1, 1, 1, 0, 0,   0, 4'b0000, 0, 0};
    tbl[3]  = '{0, 1, 1, 1, 0, 0,   0, 4'b0000, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 0,   1, 4'b0000, 0, 0};
    tbl[5]  = '{0, 1, 1, 1, 0, 0,   1, 4'b0000, 0, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0,   1, 4'b0010, 0, 0};
    tbl[7]  = '{0, 1, 3, 1, 0, 0,   1, 4'b0010, 0, 0};
    tbl[8]  = '{0, 1, 7, 1, 0, 0,   1, 4'b1010, 1, 0};
    tbl[9]  = '{0, 0, 0, 0, 0, 0,   1, 4'b1010, 0, 1};
    tbl[10] = '{0, 1, 1, 0, 0, 0,   1, 4'b1010, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 0, 0,   1, 4'b1000, 0, 0};
    tbl[12] = '{0, 1, 15, 2, 3, 0,  1, 4'b1000, 1, 0};
    tbl[13] = '{0, 1, 3, 0, 0, 0,   1, 4'b1000, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 0,   1, 4'b0000, 0, 0};

    for (int i = 0; i < 15; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].ch, tbl[i].md, tbl[i].per, tbl[i].dty,
           or_, oe, ot, ol, er, ee, et, el);
      chk($sformatf("vec%0d_ready", i), 32'(or_), 32'(tbl[i].x_ready));
      chk($sformatf("vec%0d_led", i),   32'(ol),  32'(tbl[i].x_led));
      chk($sformatf("vec%0d_err", i),   32'(oe),  32'(tbl[i].x_err));
      chk($sformatf("vec%0d_tick", i),  32'(ot),  32'(tbl[i].x_tick));
      last_led = ol;
    end

    // Blink, period 3: toggles every 3 ticks, first toggle 3 ticks after the write.
    run_chk(0, 1, 0, 2, 3, 0);
    w = t_now;
    chg.delete();
    for (int k = 0; k < 60 && chg.size() < 3; k++) begin
      run_chk(0, 0, 0, 0, 0, 0);
      if (t_now >= w + 2 && last_led[0] != prev_led[0]) chg.push_back(t_now);
    end
    chk("blink3_toggles", chg.size(), 3);
    if (chg.size() == 3) begin
      chk("blink3_first", chg[0] - w, ((w / TD) + 3) * TD + 1 - w);
      chk("blink3_half_a", chg[1] - chg[0], 3 * TD);
      chk("blink3_half_b", chg[2] - chg[1], 3 * TD);
    end

    // Blink, period 0 acts as 1: toggles every tick.
    run_chk(0, 1, 0, 2, 0, 0);
    w = t_now;
    chg.delete();
    for (int k = 0; k < 30 && chg.size() < 3; k++) begin
      run_chk(0, 0, 0, 0, 0, 0);
      if (t_now >= w + 2 && last_led[0] != prev_led[0]) chg.push_back(t_now);
    end
    chk("blink0_toggles", chg.size(), 3);
    if (chg.size() == 3) begin
      chk("blink0_half_a", chg[1] - chg[0], TD);
      chk("blink0_half_b", chg[2] - chg[1], TD);
    end

    // Write landing on a tick edge: tick ignored, first toggle a full period later.
    run_chk(0, 1, 0, 0, 0, 0);
    run_chk(0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 2 * TD && ((t_now + 1) % TD) != 0; k++) run_chk(0, 0, 0, 0, 0, 0);
    run_chk(0, 1, 0, 2, 2, 0);
    w = t_now;
    chg.delete();
    for (int k = 0; k < 30 && chg.size() < 1; k++) begin
      run_chk(0, 0, 0, 0, 0, 0);
      if (last_led[0] != prev_led[0]) chg.push_back(t_now);
    end
    chk("collide_toggles", chg.size(), 1);
    if (chg.size() == 1) chk("collide_first", chg[0] - w, 2 * TD + 1);

    // PWM high count over one full 256-cycle frame.
    duties[0] = 64; duties[1] = 0; duties[2] = 255;
    for (int d = 0; d < 3; d++) begin
      run_chk(0, 1, 2, 3, 0, duties[d]);
      run_chk(0, 0, 0, 0, 0, 0);
      hi = 0;
      for (int k = 0; k < 256; k++) begin
        run_chk(0, 0, 0, 0, 0, 0);
        if (last_led[2]) hi++;
      end
      chk($sformatf("pwm_duty%0d_high", duties[d]), hi, duties[d]);
    end

    // Randomized traffic, including occasional mid-run resets and bad channels.
    for (int k = 0; k < 1500; k++) begin
      run_chk($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 7), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 255));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
